pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Program-counter and fetch sequencer that sits directly around the jump-target lookup stage. It holds the 12-bit PC, drives the lookup's address and jump inputs, and captures the registered next-PC target one cycle later. It also runs the start/halt/done handshake with the testbench and decoder, and keeps cycle and instruction counters plus a watchdog timeout.

Parameters:
D, 12, PC / address width
START_PC, 0, PC value loaded on start
CW, 16, width of cycle and instruction counters
MAX_CYCLES, 4096, watchdog limit in active cycles; 0 disables the watchdog

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins execution from IDLE or HALT
stall  input  1  holds the current instruction in EXEC
jump_req  input  1  decoder: current instruction is a taken branch
halt_req  input  1  decoder: current instruction is halt
lut_target  input  D  registered next-PC from the lookup stage
lut_addr  output  D  address presented to the lookup stage (= pc)
lut_jump  output  1  jump qualifier to the lookup stage
pc  output  D  current program counter / instruction ROM address
instr_valid  output  1  instruction at pc is being executed this cycle
done  output  1  program finished; held high in HALT
timeout  output  1  HALT was reached via the watchdog
cycle_count  output  CW  active cycles since start
instr_count  output  CW  instructions retired since start

Behaviour:
- Reset (async, reset_n=0): state=IDLE; pc=START_PC; done=0; timeout=0; both counters=0; instr_valid=0; lut_jump=0.
- States:
  - IDLE
  - EXEC: instruction at pc is live.
  - WAIT: lookup result is in flight.
  - HALT
- IDLE: outputs quiescent. On start: pc<=START_PC, counters<=0, timeout<=0, go to EXEC.
- EXEC:
  - instr_valid=1.
  - lut_addr=pc (combinational, in every state).
  - lut_jump=jump_req & ~stall & ~halt_req (combinational, EXEC only; 0 in all other states).
  - stall=1: remain in EXEC; instr_count unchanged.
  - Else if halt_req: go to HALT, instr_count+1.
  - Else: go to WAIT, instr_count+1.
  - halt_req wins over jump_req when both are high.
- WAIT:
  - instr_valid=0.
  - The lookup registered its target at the EXEC->WAIT edge; at the WAIT exit edge, pc<=lut_target and go to EXEC.
  - Fixed cost is 2 cycles per unstalled instruction.
- HALT:
  - done=1, pc frozen, counters frozen.
  - start restarts exactly as from IDLE, and done drops on the next cycle.
- start is ignored in EXEC and WAIT.
- cycle_count increments every cycle spent in EXEC or WAIT, including stalled cycles. Both counters saturate at all-ones and never wrap.
- Watchdog (MAX_CYCLES != 0): if, in EXEC or WAIT, cycle_count == MAX_CYCLES-1, go to HALT and set timeout=1. This takes priority over halt_req and over the pc update.
- PC arithmetic is mod 2^D. pc only ever takes lut_target or START_PC and never computes its own increment, so wrap is inherited from the lookup (e.g. 0xFFF+1 = 0x000).
- Reset asserted mid-operation returns immediately to IDLE with all reset values. Any in-flight lookup result is discarded.
- Outputs done, timeout, pc, and the counters are registered. instr_valid and lut_jump are decoded from the state register and must be glitch-free.

Test Plan:
- Reset, then start with no branches; lut_target models addr+1 registered -> pc sequence 0,1,2,3 with each value held for 2 cycles; instr_count=3 after 6 cycles.
- At pc=4, jump_req=1 with lookup offset -1 (0xFFF) -> lut_jump=1 during EXEC; pc=3 after WAIT; instr_count increments once.
- stall held for 3 cycles at pc=2 -> pc stays 2 and instr_valid=1 throughout; cycle_count +3 while instr_count unchanged; then normal advance to 3.
- halt_req and jump_req both asserted at pc=5 -> HALT, done=1, pc=5, lut_jump=0, timeout=0; a later start pulse -> pc=START_PC, counters=0, done=0.
- MAX_CYCLES=8 with a self-loop branch (offset 0) -> HALT after 8 active cycles with timeout=1 and done=1; cycle_count=7 frozen.
- reset_n dropped during WAIT -> outputs go immediately to IDLE reset values; lut_target changes afterwards are ignored; start resumes from START_PC.

Source files
------------

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: handshake, decoder and lookup-stage signals around the fetch sequencer
interface pc_fetch_if #(
  parameter int D = 12,
  parameter int CW = 16
);
  logic start, stall, jump_req, halt_req;
  logic [D-1:0] lut_target, lut_addr, pc;
  logic lut_jump, instr_valid, done, timeout;
  logic [CW-1:0] cycle_count, instr_count;
  modport master (
    output start, stall, jump_req, halt_req, lut_target,
    input lut_addr, lut_jump, pc, instr_valid, done, timeout, cycle_count, instr_count
  );
  modport slave (
    input start, stall, jump_req, halt_req, lut_target,
    output lut_addr, lut_jump, pc, instr_valid, done, timeout, cycle_count, instr_count
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC register and fetch sequencer around a registered jump-target lookup
module pc_fetch_ctrl #(
  parameter int D = 12,
  parameter int START_PC = 0,
  parameter int CW = 16,
  parameter int MAX_CYCLES = 4096
) (
  input logic clk,
  input logic reset_n,
  pc_fetch_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, WAIT, HALT} state_t;
  localparam logic [CW-1:0] WD_LAST = CW'(MAX_CYCLES - 1);
  state_t state;
  logic [D-1:0] pc;
  logic [CW-1:0] cyc, ins;
  logic done, timeout, active, wd;
  assign active = state == EXEC || state == WAIT;
  assign wd = MAX_CYCLES != 0 && active && cyc == WD_LAST;
  assign bus.pc = pc;
  assign bus.lut_addr = pc;
  assign bus.instr_valid = state == EXEC;
  assign bus.lut_jump = state == EXEC && bus.jump_req && !bus.stall && !bus.halt_req;
  assign bus.done = done;
  assign bus.timeout = timeout;
  assign bus.cycle_count = cyc;
  assign bus.instr_count = ins;
  // the watchdog check precedes everything else so a timed-out run freezes pc and counters
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      pc <= D'(START_PC);
      cyc <= '0;
      ins <= '0;
      done <= 1'b0;
      timeout <= 1'b0;
    end else if (!active) begin
      if (bus.start) begin
        state <= EXEC;
        pc <= D'(START_PC);
        cyc <= '0;
        ins <= '0;
        done <= 1'b0;
        timeout <= 1'b0;
      end
    end else if (wd) begin
      state <= HALT;
      done <= 1'b1;
      timeout <= 1'b1;
    end else begin
      cyc <= cyc + CW'(~&cyc);
      if (state == WAIT) begin
        pc <= bus.lut_target;
        state <= EXEC;
      end else if (!bus.stall) begin
        ins <= ins + CW'(~&ins);
        state <= bus.halt_req ? HALT : WAIT;
        done <= bus.halt_req;
      end
    end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: three configurations (default, 8-cycle watchdog, 4-bit counters without watchdog) against a run-level model
module tb_pc_fetch_ctrl;
  logic clk = 0, reset_n = 0;
  logic [11:0] off = 12'd0;
  logic cs = 0, cl = 0, cj = 0, ch = 0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  pc_fetch_if #(.D(12), .CW(16)) if0 ();
  pc_fetch_if #(.D(12), .CW(16)) if1 ();
  pc_fetch_if #(.D(12), .CW(4)) if2 ();
  pc_fetch_ctrl #(.MAX_CYCLES(4096)) u0 (.clk(clk), .reset_n(reset_n), .bus(if0.slave));
  pc_fetch_ctrl #(.MAX_CYCLES(8)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));
  pc_fetch_ctrl #(.CW(4), .MAX_CYCLES(0)) u2 (.clk(clk), .reset_n(reset_n), .bus(if2.slave));
  // lookup stage: registered next PC, either pc+1 or pc+offset when jumping
  always @(posedge clk) if0.lut_target <= if0.lut_jump ? if0.lut_addr + off : if0.lut_addr + 12'd1;
  always @(posedge clk) if1.lut_target <= if1.lut_jump ? if1.lut_addr + off : if1.lut_addr + 12'd1;
  always @(posedge clk) if2.lut_target <= if2.lut_jump ? if2.lut_addr + off : if2.lut_addr + 12'd1;
  int lim[3] = '{4096, 8, 0};
  int smax[3] = '{65535, 65535, 15};
  bit m_run[3], m_fl[3], m_done[3], m_to[3];
  logic [11:0] m_pc[3], m_tgt[3];
  int m_cc[3], m_ic[3];
  task automatic chk(input string nm, input int i, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s[u%0d] t=%0t: got %0h expected %0h", nm, i, $time, a, e);
    end
  endtask
  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_run[i] = 0; m_fl[i] = 0; m_done[i] = 0; m_to[i] = 0;
      m_pc[i] = 12'd0; m_cc[i] = 0; m_ic[i] = 0;
    end
  endtask
  task automatic m_step();
    for (int i = 0; i < 3; i++) begin
      if (!m_run[i]) begin
        if (cs) begin
          m_run[i] = 1; m_fl[i] = 0; m_done[i] = 0; m_to[i] = 0;
          m_pc[i] = 12'd0; m_cc[i] = 0; m_ic[i] = 0;
        end
      end else if (lim[i] != 0 && m_cc[i] == lim[i] - 1) begin
        m_run[i] = 0; m_done[i] = 1; m_to[i] = 1;
      end else begin
        if (m_cc[i] < smax[i]) m_cc[i]++;
        if (m_fl[i]) begin
          m_pc[i] = m_tgt[i];
          m_fl[i] = 0;
        end else if (!cl) begin
          if (m_ic[i] < smax[i]) m_ic[i]++;
          if (ch) begin
            m_run[i] = 0; m_done[i] = 1;
          end else begin
            m_tgt[i] = m_pc[i] + (cj ? off : 12'd1);
            m_fl[i] = 1;
          end
        end
      end
    end
  endtask
  task automatic chk_inst(input int i, input logic [11:0] pc, input logic iv, input logic lj,
                          input logic dn, input logic to, input logic [31:0] cc, input logic [31:0] ic);
    bit live;
    live = m_run[i] && !m_fl[i];
    chk("pc", i, 32'(pc), 32'(m_pc[i]));
    chk("instr_valid", i, 32'(iv), 32'(live));
    chk("lut_jump", i, 32'(lj), 32'(live && cj && !cl && !ch));
    chk("done", i, 32'(dn), 32'(m_done[i]));
    chk("timeout", i, 32'(to), 32'(m_to[i]));
    chk("cycle_count", i, cc, m_cc[i]);
    chk("instr_count", i, ic, m_ic[i]);
  endtask
  task automatic check_all();
    chk_inst(0, if0.pc, if0.instr_valid, if0.lut_jump, if0.done, if0.timeout, 32'(if0.cycle_count), 32'(if0.instr_count));
    chk_inst(1, if1.pc, if1.instr_valid, if1.lut_jump, if1.done, if1.timeout, 32'(if1.cycle_count), 32'(if1.instr_count));
    chk_inst(2, if2.pc, if2.instr_valid, if2.lut_jump, if2.done, if2.timeout, 32'(if2.cycle_count), 32'(if2.instr_count));
  endtask
  task automatic set_in(input logic s, input logic l, input logic j, input logic h);
    cs = s; cl = l; cj = j; ch = h;
    if0.start = s; if0.stall = l; if0.jump_req = j; if0.halt_req = h;
    if1.start = s; if1.stall = l; if1.jump_req = j; if1.halt_req = h;
    if2.start = s; if2.stall = l; if2.jump_req = j; if2.halt_req = h;
  endtask
  task automatic tick(input logic s, input logic l, input logic j, input logic h);
    set_in(s, l, j, h);
    #1 check_all();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask
  task automatic do_reset();
    #3 reset_n = 0;
    #1 m_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask
  initial begin
    set_in(0, 0, 0, 0);
    m_reset();
    @(negedge clk);
    #1 check_all();
    chk("lit_reset_pc", 0, 32'(if0.pc), 32'h0);
    chk("lit_reset_done", 0, 32'(if0.done), 32'h0);
    @(negedge clk);
    reset_n = 1;
    tick(1, 0, 0, 0);
    repeat (6) tick(0, 0, 0, 0);
    chk("lit_seq_pc", 0, 32'(if0.pc), 32'd3);
    chk("lit_seq_instr", 0, 32'(if0.instr_count), 32'd3);
    chk("lit_seq_cycle", 0, 32'(if0.cycle_count), 32'd6);
    repeat (2) tick(0, 0, 0, 0);
    chk("lit_wd_timeout", 1, 32'(if1.timeout), 32'd1);
    chk("lit_wd_done", 1, 32'(if1.done), 32'd1);
    chk("lit_wd_cycle", 1, 32'(if1.cycle_count), 32'd7);
    chk("lit_wd_pc", 1, 32'(if1.pc), 32'd3);
    chk("lit_jmp_at", 0, 32'(if0.pc), 32'd4);
    off = 12'hFFF;
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    chk("lit_jmp_pc", 0, 32'(if0.pc), 32'd3);
    chk("lit_jmp_instr", 0, 32'(if0.instr_count), 32'd5);
    tick(0, 0, 1, 1);
    chk("lit_halt_done", 0, 32'(if0.done), 32'd1);
    chk("lit_halt_pc", 0, 32'(if0.pc), 32'd3);
    chk("lit_halt_to", 0, 32'(if0.timeout), 32'd0);
    tick(0, 0, 1, 0);
    tick(1, 0, 0, 0);
    chk("lit_restart_pc", 0, 32'(if0.pc), 32'd0);
    chk("lit_restart_done", 0, 32'(if0.done), 32'd0);
    chk("lit_restart_instr", 0, 32'(if0.instr_count), 32'd0);
    repeat (3) tick(0, 1, 0, 0);
    chk("lit_stall_cycle", 0, 32'(if0.cycle_count), 32'd3);
    chk("lit_stall_instr", 0, 32'(if0.instr_count), 32'd0);
    chk("lit_stall_valid", 0, 32'(if0.instr_valid), 32'd1);
    tick(0, 0, 0, 0);
    do_reset();
    chk("lit_rst_wait_pc", 0, 32'(if0.pc), 32'd0);
    chk("lit_rst_wait_cycle", 0, 32'(if0.cycle_count), 32'd0);
    tick(1, 0, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      off = 12'($urandom);
      tick($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 49) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
